// File: rtl/parity_rx_pkg.sv
// Shared constants for the parity frame receiver: FSM state encoding and frame-format bit levels.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package parity_rx_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // Frame-format line levels
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/xor_gate.sv
// N-input XOR reduction; the shared primitive of the parity generator/checker path.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
//
// Ports:
//   in_bits  input  [N-1:0]  bits to be XOR-reduced
//   out_bit  output          XOR of all in_bits
module xor_gate #(
  parameter int N = 2
) (
  input  logic [N-1:0] in_bits,
  output logic         out_bit
);

  assign out_bit = ^in_bits;

endmodule

// File: rtl/parity_frame_rx.sv
// Bit-serial start/data/parity/stop frame receiver with parity and framing check.
// Latency: data_valid in the cycle after the stop bit is sampled (DATA_W+3 clocks from start bit, gap-free).
// Backpressure: none; bit_valid low freezes the receiver, words are delivered as one-cycle pulses.
//
// Ports:
//   clk         input            rising-edge clock
//   rst_n       input            asynchronous active-low reset
//   rx_bit      input            serial line, idles high
//   bit_valid   input            qualifies rx_bit; FSM advances only when high
//   data_out    output [DATA_W]  last received word
//   data_valid  output           one-cycle pulse when data_out/parity_err/frame_err update
//   parity_err  output           parity mismatch on last frame, held until next data_valid
//   frame_err   output           stop bit was low on last frame, held until next data_valid
//   busy        output           high in every state except IDLE
module parity_frame_rx
  import parity_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_bit,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              acc;
  logic              perr;

  logic              acc_nxt;
  logic              perr_nxt;

  // Running parity over the data bits.
  xor_gate #(.N(2)) u_acc_xor (
    .in_bits ({acc, rx_bit}),
    .out_bit (acc_nxt)
  );

  // Data parity XOR received parity bit XOR expected sense: 1 means mismatch.
  xor_gate #(.N(3)) u_par_xor (
    .in_bits ({acc, rx_bit, 1'(ODD_PARITY)}),
    .out_bit (perr_nxt)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      acc        <= 1'b0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Pulse only; a gap cycle after STOP must not stretch it.
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (rx_bit == START_BIT) begin
              state   <= DATA;
              bit_cnt <= '0;
              acc     <= 1'b0;
            end
          end
          DATA: begin
            // LSB arrives first, so shifting right leaves it in bit 0 after DATA_W bits.
            shift_reg <= {rx_bit, shift_reg[DATA_W-1:1]};
            acc       <= acc_nxt;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            perr  <= perr_nxt;
            state <= STOP;
          end
          STOP: begin
            // Deliver even on error; the consumer decides what to do with it.
            data_out   <= shift_reg;
            parity_err <= perr;
            frame_err  <= (rx_bit != STOP_BIT);
            data_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
